addsub_pipe: RTL and testbench
==============================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. Generalises the team's 32-bit ripple adder to any width, and splits the carry chain into STAGES registered segments.
- Adds a valid/ready handshake on both sides, an add/sub mode, and carry, overflow and zero flags.
- Sits between the register-file operand mux and the writeback path. Used wherever a wide add must meet timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; range 1..WIDTH; the segment width is SEG = WIDTH/STAGES.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- n_rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  operand beat is valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- op_sub  in  1  0 = A+B+cin; 1 = A-B-cin.
- out_valid  out  1  result beat is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  raw carry out of the MSB.
- ovf  out  1  signed overflow.
- zero  out  1  high when sum == 0.

Behaviour:
- Operand conditioning:
  - b_eff = op_sub ? ~b : b.
  - c0 = op_sub ? ~cin : cin.
  - Sub with cin=0 therefore gives A-B. Sub with cin=1 gives A-B-1.
- Pipeline structure:
  - Stage k (0-based) adds bits [k*SEG +: SEG] of a and b_eff, using the carry registered by stage k-1 (c0 for stage 0).
  - Upper operand slices are delay-registered alongside the data (skewed pipeline). Lower result slices are delay-registered to align at the output.
- Latency and throughput:
  - Accept-to-out_valid latency is exactly STAGES cycles. STAGES=1 gives one registered cycle.
  - Throughput is one beat per cycle when unstalled.
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A result is consumed when out_valid && out_ready.
  - in_ready = out_ready || !out_valid. This is the global-stall rule: when the output is held, every stage holds.
  - Bubbles propagate as per-stage valid bits. Bubbles are not compressed.
  - sum and all flags stay stable while out_valid && !out_ready.
- Flags, all aligned with sum:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0), computed in the final stage.
- Reset (n_rst low at a clock edge):
  - All stage valid bits clear, so out_valid=0.
  - sum, cout, ovf and zero clear to 0.
  - In-flight beats are discarded, including on reset mid-operation.
  - in_ready may be high while reset is asserted, but beats presented in a reset cycle are dropped.
- Simultaneous accept and consume: the pipeline advances by one. There is no loss and no duplication.
- Wrap-around: results are modulo 2^WIDTH. Overflow is reported only through cout/ovf.

Optional Feature:
- Macro: ADDSUB_PIPE_SAT_EN.
- Defined: when ovf=1, sum is forced to signed saturation. The value is 0x7FF..F if the true result is positive (MSB of a is 0), otherwise 0x800..0. ovf and cout still report raw values. zero reflects the saturated sum.
- Undefined: sum is always the wrapped result, and no saturation logic is instantiated.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} addsub_op_t.
  - typedef struct packed {cout, ovf, zero} addsub_flags_t.
- Sub-module addsub_seg: combinational SEG-bit ripple segment.
  - Inputs: a, b, ci.
  - Outputs: s, co, plus c_msb_in for the final-segment overflow calculation.
  - Instantiated STAGES times in a generate loop.

Test Plan (WIDTH=32, STAGES=4):
- Reset: hold n_rst=0 for 2 cycles with in_valid=1 -> out_valid=0, sum=0, flags=0; nothing emerges 4 cycles after release.
- Add: a=0xFFFF_FFFF, b=1, cin=0, op_sub=0 -> exactly 4 cycles later sum=0, cout=1, ovf=0, zero=1.
- Sub and overflow:
  - a=5, b=7, op_sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
  - a=0x7FFF_FFFF, b=1, op_sub=0 -> sum=0x8000_0000, ovf=1 (with ADDSUB_PIPE_SAT_EN: sum=0x7FFF_FFFF).
- Back-to-back beats: 8 consecutive beats with out_ready=1 -> 8 results on consecutive cycles starting at cycle 4, in order.
- Backpressure: drop out_ready for 3 cycles mid-stream -> in_ready=0 during the hold, sum held stable, no lost or duplicated beats after release.
- Reset mid-flight: assert n_rst=0 with 3 beats in flight -> all discarded, out_valid=0 the next cycle.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared types for the pipelined adder/subtractor
package addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } addsub_op_t;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
    } addsub_flags_t;

endpackage

// File: rtl/addsub_seg.sv
// addsub_seg: combinational SEG-bit carry segment, also exposing the carry into its MSB
module addsub_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb_in
);

    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c
    always_comb begin
        {co, s}  = (SEG + 1)'(a) + (SEG + 1)'(b) + (SEG + 1)'(ci);
        c_msb_in = a[SEG-1] ^ b[SEG-1] ^ s[SEG-1];
    end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: skewed STAGES-deep add/sub pipeline with valid/ready; define ADDSUB_PIPE_SAT_EN for signed saturation
module addsub_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;
    localparam int L   = STAGES - 1;

    logic             en;
    logic             sub;
    logic             ovf_n;
    logic [WIDTH-1:0] s_fin;
    logic [WIDTH-1:0] a_in [STAGES];
    logic [WIDTH-1:0] b_in [STAGES];
    logic [WIDTH-1:0] s_in [STAGES];
    logic [WIDTH-1:0] s_nx [STAGES];
    logic [WIDTH-1:0] a_q  [STAGES];
    logic [WIDTH-1:0] b_q  [STAGES];
    logic [WIDTH-1:0] s_q  [STAGES];
    logic [SEG-1:0]   seg_s[STAGES];
    logic             c_in [STAGES];
    logic             v_in [STAGES];
    logic             c_q  [STAGES];
    logic             v_q  [STAGES];
    logic             co_w [STAGES];
    logic             cm_w [STAGES];
    addsub_flags_t    flags_n;
    addsub_flags_t    flags_q;

    assign sub       = addsub_op_t'(op_sub) == OP_SUB;
    assign en        = out_ready || !out_valid;
    assign in_ready  = en;
    assign out_valid = v_q[L];
    assign sum       = s_q[L];
    assign cout      = flags_q.cout;
    assign ovf       = flags_q.ovf;
    assign zero      = flags_q.zero;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign a_in[k] = a;
            assign b_in[k] = sub ? ~b : b;
            assign c_in[k] = sub ^ cin;
            assign v_in[k] = in_valid;
            assign s_in[k] = '0;
        end else begin : g_tail
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign v_in[k] = v_q[k-1];
            assign s_in[k] = s_q[k-1];
        end
        addsub_seg #(.SEG(SEG)) u_seg (
            .a        (a_in[k][k*SEG +: SEG]),
            .b        (b_in[k][k*SEG +: SEG]),
            .ci       (c_in[k]),
            .s        (seg_s[k]),
            .co       (co_w[k]),
            .c_msb_in (cm_w[k])
        );
        assign s_nx[k] = s_in[k] | (WIDTH'(seg_s[k]) << (k * SEG));
    end

    assign ovf_n = co_w[L] ^ cm_w[L];

`ifdef ADDSUB_PIPE_SAT_EN
    assign s_fin = ovf_n ? {a_in[L][WIDTH-1], {(WIDTH-1){~a_in[L][WIDTH-1]}}} : s_nx[L];
`else
    assign s_fin = s_nx[L];
`endif

    assign flags_n = '{cout: co_w[L], ovf: ovf_n, zero: s_fin == '0};

    // Advance every stage together; a held output freezes the whole pipe
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= 1'b0;
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= 1'b0;
                s_q[i] <= '0;
            end
            flags_q <= '0;
        end else if (en) begin
            for (int i = 0; i < STAGES; i++) begin
                v_q[i] <= v_in[i];
                a_q[i] <= a_in[i];
                b_q[i] <= b_in[i];
                c_q[i] <= co_w[i];
                s_q[i] <= (i == L) ? s_fin : s_nx[i];
            end
            flags_q <= flags_n;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed self-checking bench for addsub_pipe (WIDTH=32, STAGES=4)
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op_sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and wait (bounded) for its result; lat = cycles until out_valid, -1 on timeout
    task automatic send_one(input logic [31:0] va, input logic [31:0] vb, input logic vc, input logic vs, output int lat);
        lat = -1;
        in_valid = 1'b1;
        a = va;
        b = vb;
        cin = vc;
        op_sub = vs;
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (out_valid) begin
                lat = i;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        bit seen = 0;
        n_rst = 1'b0;
        in_valid = 1'b1;
        a = 32'h1;
        b = 32'h1;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {cout, ovf, zero}); end
        in_valid = 1'b0;
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_drop: got result=%b want none", seen); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add();
        int lat;
        send_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d want 4", lat); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL add_sum: got %h want 00000000", sum); end
        checks++; if ({cout, ovf, zero} !== 3'b101) begin errors++; $display("FAIL add_flags: got %b want 101", {cout, ovf, zero}); end
        step();
        send_one(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL addc_latency: got %0d want 4", lat); end
        checks++; if (sum !== 32'h2345_678A) begin errors++; $display("FAIL addc_sum: got %h want 2345678a", sum); end
        checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL addc_flags: got %b want 000", {cout, ovf, zero}); end
        step();
    endtask

    task automatic test_sub();
        int lat;
        send_one(32'd5, 32'd7, 1'b0, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sub_latency: got %0d want 4", lat); end
        checks++; if (sum !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_sum: got %h want fffffffe", sum); end
        checks++; if ({cout, ovf, zero} !== 3'b000) begin errors++; $display("FAIL sub_flags: got %b want 000", {cout, ovf, zero}); end
        step();
        send_one(32'd10, 32'd3, 1'b1, 1'b1, lat);
        checks++; if (sum !== 32'd6) begin errors++; $display("FAIL subb_sum: got %h want 00000006", sum); end
        checks++; if ({cout, ovf, zero} !== 3'b100) begin errors++; $display("FAIL subb_flags: got %b want 100", {cout, ovf, zero}); end
        step();
        send_one(32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, lat);
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL subz_sum: got %h want 00000000", sum); end
        checks++; if ({cout, ovf, zero} !== 3'b101) begin errors++; $display("FAIL subz_flags: got %b want 101", {cout, ovf, zero}); end
        step();
    endtask

    task automatic test_overflow();
        int lat;
        logic [31:0] pos_exp;
        logic [31:0] neg_exp;
`ifdef ADDSUB_PIPE_SAT_EN
        pos_exp = 32'h7FFF_FFFF;
        neg_exp = 32'h8000_0000;
`else
        pos_exp = 32'h8000_0000;
        neg_exp = 32'h7FFF_FFFF;
`endif
        send_one(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, lat);
        checks++; if (sum !== pos_exp) begin errors++; $display("FAIL ovfp_sum: got %h want %h", sum, pos_exp); end
        checks++; if ({cout, ovf, zero} !== 3'b010) begin errors++; $display("FAIL ovfp_flags: got %b want 010", {cout, ovf, zero}); end
        step();
        send_one(32'h8000_0000, 32'h1, 1'b0, 1'b1, lat);
        checks++; if (sum !== neg_exp) begin errors++; $display("FAIL ovfn_sum: got %h want %h", sum, neg_exp); end
        checks++; if ({cout, ovf, zero} !== 3'b110) begin errors++; $display("FAIL ovfn_flags: got %b want 110", {cout, ovf, zero}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] va[8];
        logic [31:0] vb[8];
        int rcv = 0;
        for (int i = 0; i < 8; i++) begin
            va[i] = 32'h0101_0101 * i;
            vb[i] = 32'h0000_F00F + i;
        end
        out_ready = 1'b1;
        cin = 1'b0;
        op_sub = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            in_valid = cyc < 8;
            a = cyc < 8 ? va[cyc] : 32'h0;
            b = cyc < 8 ? vb[cyc] : 32'h0;
            step();
            if (out_valid) begin
                checks++; if (cyc + 1 !== rcv + 4) begin errors++; $display("FAIL b2b_cycle%0d: got cycle %0d want %0d", rcv, cyc + 1, rcv + 4); end
                if (rcv < 8) begin
                    checks++; if (sum !== va[rcv] + vb[rcv]) begin errors++; $display("FAIL b2b_sum%0d: got %h want %h", rcv, sum, va[rcv] + vb[rcv]); end
                end
                rcv++;
            end
        end
        in_valid = 1'b0;
        checks++; if (rcv !== 8) begin errors++; $display("FAIL b2b_count: got %0d want 8", rcv); end
    endtask

    task automatic test_backpressure();
        logic [31:0] va[8];
        logic [31:0] vb[8];
        logic [31:0] held_sum = '0;
        bit held = 0;
        int sent = 0;
        int rcv = 0;
        for (int i = 0; i < 8; i++) begin
            va[i] = 32'h0010_0000 * i + 32'h0000_0300;
            vb[i] = 32'h0000_0100 * i + 32'h0000_00AB;
        end
        cin = 1'b0;
        op_sub = 1'b0;
        for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
            out_ready = !(cyc >= 6 && cyc < 9);
            in_valid = sent < 8;
            a = sent < 8 ? va[sent] : 32'h0;
            b = sent < 8 ? vb[sent] : 32'h0;
            #1;
            if (out_valid && out_ready) begin
                checks++; if (sum !== va[rcv] + vb[rcv]) begin errors++; $display("FAIL bp_sum%0d: got %h want %h", rcv, sum, va[rcv] + vb[rcv]); end
                rcv++;
                held = 0;
            end else if (out_valid) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c%0d: got %b want 0", cyc, in_ready); end
                if (held) begin
                    checks++; if (sum !== held_sum) begin errors++; $display("FAIL bp_hold_c%0d: got %h want %h", cyc, sum, held_sum); end
                end
                held = 1;
                held_sum = sum;
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++; if (rcv !== 8 || sent !== 8) begin errors++; $display("FAIL bp_count: got sent=%0d rcv=%0d want 8/8", sent, rcv); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup: got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        out_ready = 1'b1;
        cin = 1'b0;
        op_sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'h0000_1000 + i;
            b = 32'h0000_0001;
            step();
        end
        in_valid = 1'b0;
        n_rst = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", out_valid); end
        checks++; if (sum !== 32'h0) begin errors++; $display("FAIL mid_sum: got %h want 0", sum); end
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_drop: got result=%b want none", seen); end
    endtask

    initial begin
        n_rst = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        op_sub = 1'b0;
        out_ready = 1'b1;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
